v60_prefetch_queue: RTL and testbench

V60_PREFETCH_QUEUE -- requirements
Module: v60_prefetch_queue

---
 rtl/v60_prefetch_queue.sv | 151 +++++++++++++++
 tb/tb_v60_prefetch_queue.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/v60_prefetch_queue.sv
// Instruction prefetch queue: an 8-byte circular byte buffer filled by word
// fetches from memory and drained by the decoder up to 4 bytes per cycle.
module v60_prefetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        pf_req,
  output logic [31:0] pf_addr,
  output logic [1:0]  pf_size,
  input  logic [31:0] pf_rdata,
  input  logic        pf_ready,
  output logic [31:0] q_data,
  output logic [3:0]  q_count,
  output logic [31:0] q_pc,
  input  logic [2:0]  consume
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_GAP} state_e;

  state_e      state_q, state_d;
  logic [29:0] addr_q, addr_d;       // word address of the current/next fetch
  logic [1:0]  skip_q, skip_d;
  logic [31:0] pend_q, pend_d;       // flush target held while a dropped word is outstanding
  logic        discard_q, discard_d;
  logic [2:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  wr_ptr_q, wr_ptr_d;
  logic [3:0]  count_q, count_d;
  logic [31:0] pc_q, pc_d;
  logic [7:0]  mem_q [8];

  logic [3:0]  consume_eff;
  logic        complete;
  logic        append;
  logic [2:0]  n_app;
  logic [7:0]  mem_we;
  logic [7:0]  mem_wdata [8];

  // NOTE: every signal written below gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    skip_d    = skip_q;
    pend_d    = pend_q;
    discard_d = discard_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    pc_d      = pc_q;

    consume_eff = ({1'b0, consume} > count_q) ? count_q : {1'b0, consume};
    complete    = (state_q == S_BUSY) && pf_ready;
    append      = complete && !discard_q && !flush;
    n_app       = 3'd4 - {1'b0, skip_q};

    case (state_q)
      S_IDLE:  if (!flush && ((count_q - consume_eff) <= 4'd4)) state_d = S_BUSY;
      S_BUSY:  if (pf_ready) state_d = S_GAP;
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      count_d  = 4'd0;
      rd_ptr_d = 3'd0;
      wr_ptr_d = 3'd0;
      pc_d     = flush_pc;
      // An in-flight request cannot be aborted, so remember the target until it returns.
      if ((state_q == S_BUSY) && !pf_ready) begin
        discard_d = 1'b1;
        pend_d    = flush_pc;
      end else begin
        addr_d    = flush_pc[31:2];
        skip_d    = flush_pc[1:0];
        discard_d = 1'b0;
      end
    end else begin
      rd_ptr_d = rd_ptr_q + consume_eff[2:0];
      pc_d     = pc_q + 32'(consume_eff);
      count_d  = count_q - consume_eff + (append ? {1'b0, n_app} : 4'd0);
      if (append) begin
        wr_ptr_d = wr_ptr_q + n_app;
        addr_d   = addr_q + 30'd1;
        skip_d   = 2'd0;
      end else if (complete) begin
        addr_d    = pend_q[31:2];
        skip_d    = pend_q[1:0];
        discard_d = 1'b0;
      end
    end
  end

  // Byte lanes of the fetched word, steered into the slots following the write pointer.
  always_comb begin
    for (int j = 0; j < 8; j++) begin
      logic [2:0] off;
      logic [1:0] sel;
      off          = 3'(j) - wr_ptr_q;
      sel          = off[1:0] + skip_q;
      mem_we[j]    = append && (off < n_app);
      mem_wdata[j] = pf_rdata[{sel, 3'b000} +: 8];
    end
  end

  always_comb begin
    q_data = 32'd0;
    for (int i = 0; i < 4; i++) begin
      if (4'(i) < count_q) q_data[8*i +: 8] = mem_q[rd_ptr_q + 3'(i)];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= RESET_PC[31:2];
      skip_q    <= RESET_PC[1:0];
      pend_q    <= 32'd0;
      discard_q <= 1'b0;
      rd_ptr_q  <= 3'd0;
      wr_ptr_q  <= 3'd0;
      count_q   <= 4'd0;
      pc_q      <= RESET_PC;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      skip_q    <= skip_d;
      pend_q    <= pend_d;
      discard_q <= discard_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      pc_q      <= pc_d;
    end
  end

  // NOTE: the byte storage has no reset; slots at or beyond the occupancy are masked on q_data.
  always_ff @(posedge clk) begin
    for (int j = 0; j < 8; j++) begin
      if (mem_we[j]) mem_q[j] <= mem_wdata[j];
    end
  end

  assign pf_req  = (state_q == S_BUSY);
  assign pf_addr = {addr_q, 2'b00};
  assign pf_size = 2'b10;
  assign q_count = count_q;
  assign q_pc    = pc_q;

endmodule

// File: tb/tb_v60_prefetch_queue.sv
// Directed bench for v60_prefetch_queue: a latency-programmable memory
// responder, a queue-level reference model checked every cycle, and literal checks.
module tb_v60_prefetch_queue;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [31:0] flush_pc;
  logic        pf_req;
  logic [31:0] pf_addr;
  logic [1:0]  pf_size;
  logic [31:0] pf_rdata = 32'd0;
  logic        pf_ready = 1'b0;
  logic [31:0] q_data;
  logic [3:0]  q_count;
  logic [31:0] q_pc;
  logic [2:0]  consume;

  v60_prefetch_queue #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .flush_pc(flush_pc),
    .pf_req(pf_req), .pf_addr(pf_addr), .pf_size(pf_size),
    .pf_rdata(pf_rdata), .pf_ready(pf_ready),
    .q_data(q_data), .q_count(q_count), .q_pc(q_pc), .consume(consume)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory responder: pf_ready rises after lat idle request cycles.
  logic [7:0] mem [512];
  int lat  = 1;
  int wcnt = 0;
  always @(negedge clk) begin
    int b;
    b = int'(pf_addr[8:0]);
    if (pf_req) begin
      if (wcnt == lat) begin
        pf_ready = 1'b1;
        pf_rdata = {mem[(b+3)&511], mem[(b+2)&511], mem[(b+1)&511], mem[b]};
      end else begin
        pf_ready = 1'b0;
        pf_rdata = $urandom;
      end
      wcnt++;
    end else begin
      wcnt     = 0;
      pf_ready = 1'b0;
      pf_rdata = $urandom;
    end
  end

  // Reference model: byte queue, head pc, and the address/skip of the next fetch.
  logic [7:0]  mq [$];
  logic [31:0] mpc, maddr, mpend;
  logic [1:0]  mskip;
  bit          mdisc, mbusy, mgap, mdone, mstart;
  int          m_ce;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mpc   = RESET_PC;
      maddr = {RESET_PC[31:2], 2'b00};
      mskip = RESET_PC[1:0];
      mdisc = 1'b0;
      mbusy = 1'b0;
      mgap  = 1'b0;
    end else begin
      m_ce   = (int'(consume) > mq.size()) ? mq.size() : int'(consume);
      mdone  = mbusy && pf_ready;
      mstart = !mbusy && !mgap && !flush && ((mq.size() - m_ce) <= 4);
      if (flush) begin
        mq.delete();
        mpc = flush_pc;
        if (mbusy && !pf_ready) begin
          mdisc = 1'b1;
          mpend = flush_pc;
        end else begin
          maddr = {flush_pc[31:2], 2'b00};
          mskip = flush_pc[1:0];
          mdisc = 1'b0;
        end
      end else begin
        for (int k = 0; k < m_ce; k++) void'(mq.pop_front());
        mpc = mpc + 32'(m_ce);
        if (mdone && mdisc) begin
          mdisc = 1'b0;
          maddr = {mpend[31:2], 2'b00};
          mskip = mpend[1:0];
        end else if (mdone) begin
          for (int k = int'(mskip); k < 4; k++) mq.push_back(pf_rdata[8*k +: 8]);
          maddr = maddr + 32'd4;
          mskip = 2'd0;
        end
      end
      mgap  = mdone;
      mbusy = mdone ? 1'b0 : (mbusy || mstart);
    end
  end

  bit          run_cmp = 1'b0;
  logic [31:0] exp_data;
  always @(negedge clk) begin
    if (run_cmp) begin
      exp_data = 32'd0;
      for (int i = 0; i < 4; i++) if (i < mq.size()) exp_data[8*i +: 8] = mq[i];
      check("cyc_pf_req", 32'(pf_req), 32'(mbusy));
      if (mbusy) check("cyc_pf_addr", pf_addr, maddr);
      check("cyc_pf_size", 32'(pf_size), 32'd2);
      check("cyc_q_count", 32'(q_count), 32'(mq.size()));
      check("cyc_q_pc", q_pc, mpc);
      check("cyc_q_data", q_data, exp_data);
    end
  end

  task automatic wait_complete(input string nm, input logic [2:0] cons, output logic [31:0] a);
    bit got;
    got = 1'b0;
    a   = 32'hFFFF_FFFF;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk); #1;
      if (pf_req && pf_ready) begin
        got = 1'b1;
        a   = pf_addr;
      end
    end
    check({nm, "_seen"}, 32'(got), 32'd1);
    consume = cons;
    @(posedge clk); #1;
    consume = 3'd0;
  endtask

  task automatic wait_req(input string nm);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk); #1;
      if (pf_req) got = 1'b1;
    end
    check({nm, "_seen"}, 32'(got), 32'd1);
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] a;

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'(i * 7 + 3);
    {mem[0], mem[1], mem[2], mem[3]}         = {8'hB8, 8'h34, 8'h12, 8'h00};
    {mem[4], mem[5], mem[6], mem[7]}         = {8'h00, 8'hB9, 8'h78, 8'h56};
    {mem[8], mem[9], mem[10], mem[11]}       = {8'hA8, 8'hA9, 8'h01, 8'hC1};
    {mem[256], mem[257], mem[258], mem[259]} = {8'h11, 8'h22, 8'h33, 8'h44};
    {mem[260], mem[261], mem[262], mem[263]} = {8'h55, 8'h66, 8'h77, 8'h88};
    rst_n = 1'b0; flush = 1'b0; flush_pc = 32'd0; consume = 3'd0;

    repeat (3) @(negedge clk); #1;
    check("rst_pf_req", 32'(pf_req), 32'd0);
    check("rst_q_count", 32'(q_count), 32'd0);
    check("rst_q_pc", q_pc, RESET_PC);
    check("rst_q_data", q_data, 32'd0);
    check("rst_pf_addr", pf_addr, 32'd0);
    run_cmp = 1'b1;
    rst_n   = 1'b1;

    // Fill from reset with no consumption: two fetches, then stop.
    wait_complete("fetch0", 3'd0, a);
    check("fetch0_addr", a, 32'h0);
    check("fetch0_count", 32'(q_count), 32'd4);
    check("fetch0_data", q_data, 32'h0012_34B8);
    wait_complete("fetch4", 3'd0, a);
    check("fetch4_addr", a, 32'h4);
    check("fetch4_count", 32'(q_count), 32'd8);
    check("fetch4_data", q_data, 32'h0012_34B8);
    repeat (10) step();
    check("no_third_fetch", 32'(pf_req), 32'd0);

    // Draining and a consume on the completion edge.
    consume = 3'd3; step(); consume = 3'd0;
    check("c3_count", 32'(q_count), 32'd5);
    check("c3_pc", q_pc, 32'd3);
    check("c3_data", q_data, 32'h78B9_0000);
    consume = 3'd1; step(); consume = 3'd0;
    check("c1_req", 32'(pf_req), 32'd1);
    check("c1_count", 32'(q_count), 32'd4);
    wait_complete("fetch8", 3'd3, a);
    check("fetch8_addr", a, 32'h8);
    check("fetch8_count", 32'(q_count), 32'd5);
    check("fetch8_pc", q_pc, 32'd7);
    check("fetch8_data", q_data, 32'h01A9_A856);
    consume = 3'd3; step(); consume = 3'd0;
    check("c3b_count", 32'(q_count), 32'd2);
    consume = 3'd4; step(); consume = 3'd0;
    check("under_count", 32'(q_count), 32'd0);
    check("under_pc", q_pc, 32'hC);
    check("under_req_addr", pf_addr, 32'hC);

    // Flush to a misaligned pc while a request is outstanding.
    flush = 1'b1; flush_pc = 32'hA; step(); flush = 1'b0;
    check("flA_pc", q_pc, 32'hA);
    check("flA_hold_addr", pf_addr, 32'hC);
    wait_complete("dropC", 3'd0, a);
    check("dropC_addr", a, 32'hC);
    check("dropC_count", 32'(q_count), 32'd0);
    wait_complete("fetchA", 3'd0, a);
    check("fetchA_addr", a, 32'h8);
    check("fetchA_count", 32'(q_count), 32'd2);
    check("fetchA_data", q_data, 32'h0000_C101);
    check("fetchA_pc", q_pc, 32'hA);

    // Flush to 0x100 while busy at 0x8.
    flush = 1'b1; flush_pc = 32'h8; step(); flush = 1'b0;
    wait_req("req8");
    check("req8_addr", pf_addr, 32'h8);
    flush = 1'b1; flush_pc = 32'h100; step(); flush = 1'b0;
    check("fl100_count", 32'(q_count), 32'd0);
    wait_complete("drop8", 3'd0, a);
    check("drop8_addr", a, 32'h8);
    check("drop8_count", 32'(q_count), 32'd0);
    wait_complete("fetch100", 3'd0, a);
    check("fetch100_addr", a, 32'h100);
    check("fetch100_count", 32'(q_count), 32'd4);
    check("fetch100_data", q_data, 32'h4433_2211);

    // Reset in the middle of a request.
    wait_req("req104");
    rst_n = 1'b0; #1;
    check("mid_rst_req", 32'(pf_req), 32'd0);
    check("mid_rst_count", 32'(q_count), 32'd0);
    check("mid_rst_pc", q_pc, RESET_PC);
    repeat (2) @(negedge clk); #1;
    rst_n = 1'b1;
    step();
    check("rel_req", 32'(pf_req), 32'd1);
    check("rel_addr", pf_addr, 32'h0);
    wait_complete("refetch0", 3'd0, a);
    check("refetch0_data", q_data, 32'h0012_34B8);

    // Two flushes while one dropped word is outstanding: the later target wins.
    lat = 3;
    wait_req("req4");
    flush = 1'b1; flush_pc = 32'h102; step();
    flush_pc = 32'h105; step(); flush = 1'b0;
    check("fl2_pc", q_pc, 32'h105);
    check("fl2_hold_addr", pf_addr, 32'h4);
    wait_complete("drop4", 3'd0, a);
    check("drop4_addr", a, 32'h4);
    check("drop4_count", 32'(q_count), 32'd0);
    wait_complete("fetch104", 3'd0, a);
    check("fetch104_addr", a, 32'h104);
    check("fetch104_count", 32'(q_count), 32'd3);
    check("fetch104_data", q_data, 32'h0088_7766);
    check("fetch104_pc", q_pc, 32'h105);
    lat = 1;
    repeat (8) step();

    run_cmp = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
